dummy_adc_mc: RTL

Parameterised multi-channel ADC behavioural model for SoC-level simulation of the sensor path. It replaces the single-channel, display-only ADC stub with a real conversion engine. The engine has a trigger handshake, fixed conversion latency, single and scan modes, and a status word with sticky flags. Per-channel "analog" inputs are digital sample buses driven by the testbench. Results are presented to the bus-side ADC peripheral logic.

---
 rtl/dummy_adc_mc.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/dummy_adc_mc.sv
// dummy_adc_mc: multi-channel ADC behavioural model with trigger handshake,
// fixed conversion latency, single/scan modes and a sticky status word.
//
// Ports:
//   clk          in   system clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   trigger      in   start request (registered on entry)
//   mode         in   0 = single channel, 1 = scan ch_sel..NUM_CH-1
//   ch_sel       in   start channel; values >= NUM_CH are rejected
//   clear_status in   clears done/overrun/error (registered on entry)
//   analog_in    in   channel k sample at [k*ADC_BITS +: ADC_BITS]
//   measurement  out  zero-extended result, held until the next result
//   meas_ch      out  channel of the current measurement
//   meas_valid   out  one-cycle pulse per completed conversion
//   busy         out  high in any state except IDLE
//   status       out  {conv_count, 4'b0, last_ch, 3'b0, mode, error, overrun, done, busy}
module dummy_adc_mc #(
    parameter int DATA_WIDTH  = 32,
    parameter int NUM_CH      = 4,
    parameter int ADC_BITS    = 12,
    parameter int CONV_CYCLES = 8,
    localparam int CH_W       = $clog2(NUM_CH)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         trigger,
    input  logic                         mode,
    input  logic [3:0]                   ch_sel,
    input  logic                         clear_status,
    input  logic [NUM_CH*ADC_BITS-1:0]   analog_in,
    output logic [DATA_WIDTH-1:0]        measurement,
    output logic [CH_W-1:0]              meas_ch,
    output logic                         meas_valid,
    output logic                         busy,
    output logic [DATA_WIDTH-1:0]        status
);
    localparam int CNT_W = (CONV_CYCLES > 1) ? $clog2(CONV_CYCLES) : 1;
    localparam logic [4:0] NCH = 5'(NUM_CH);
    localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

    typedef enum logic [1:0] {S_IDLE, S_SAMPLE, S_CONVERT, S_DONE} state_t;

    state_t                 r_state;
    logic                   r_trig;
    logic                   r_mode_req;
    logic [3:0]             r_ch_sel;
    logic                   r_clr;
    logic [CH_W-1:0]        r_ch;
    logic                   r_mode;
    logic [ADC_BITS-1:0]    r_hold;
    logic [CNT_W-1:0]       r_cnt;
    logic [15:0]            r_conv_count;
    logic                   r_done;
    logic                   r_ovr;
    logic                   r_err;
    logic [DATA_WIDTH-1:0]  r_meas;
    logic [CH_W-1:0]        r_meas_ch;
    logic                   r_meas_valid;
    logic                   r_busy;
    logic                   w_ch_ok;

    assign w_ch_ok = {1'b0, r_ch_sel} < NCH;

    // Control inputs pass through one register stage, so trigger sampled at
    // edge E0 is acted on at E1 and the first result appears after E(CONV_CYCLES+3).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_trig       <= 1'b0;
            r_mode_req   <= 1'b0;
            r_ch_sel     <= '0;
            r_clr        <= 1'b0;
            r_ch         <= '0;
            r_mode       <= 1'b0;
            r_hold       <= '0;
            r_cnt        <= '0;
            r_conv_count <= '0;
            r_done       <= 1'b0;
            r_ovr        <= 1'b0;
            r_err        <= 1'b0;
            r_meas       <= '0;
            r_meas_ch    <= '0;
            r_meas_valid <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_trig       <= trigger;
            r_mode_req   <= mode;
            r_ch_sel     <= ch_sel;
            r_clr        <= clear_status;
            r_meas_valid <= 1'b0;
            // Clear first so that any set below on the same edge wins.
            if (r_clr) begin
                r_done <= 1'b0;
                r_ovr  <= 1'b0;
                r_err  <= 1'b0;
            end
            if (r_trig && r_state != S_IDLE)
                r_ovr <= 1'b1;
            case (r_state)
                S_IDLE: begin
                    if (r_trig) begin
                        if (w_ch_ok) begin
                            r_ch    <= r_ch_sel[CH_W-1:0];
                            r_mode  <= r_mode_req;
                            r_done  <= 1'b0;
                            r_busy  <= 1'b1;
                            r_state <= S_SAMPLE;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                S_SAMPLE: begin
                    r_hold  <= analog_in[int'(r_ch) * ADC_BITS +: ADC_BITS];
                    r_cnt   <= CNT_W'(CONV_CYCLES - 1);
                    r_state <= S_CONVERT;
                end
                S_CONVERT: begin
                    if (r_cnt == '0)
                        r_state <= S_DONE;
                    else
                        r_cnt <= r_cnt - 1'b1;
                end
                S_DONE: begin
                    r_meas       <= DATA_WIDTH'(r_hold);
                    r_meas_ch    <= r_ch;
                    r_meas_valid <= 1'b1;
                    r_done       <= 1'b1;
                    r_conv_count <= r_conv_count + 16'd1;
                    if (r_mode && r_ch < LAST_CH) begin
                        r_ch    <= r_ch + CH_W'(1);
                        r_state <= S_SAMPLE;
                    end else begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
            endcase
        end
    end

    assign measurement = r_meas;
    assign meas_ch     = r_meas_ch;
    assign meas_valid  = r_meas_valid;
    assign busy        = r_busy;
    // meas_ch is the channel of the last completed conversion.
    assign status      = DATA_WIDTH'({r_conv_count, 4'b0, 4'(r_meas_ch), 3'b0,
                                      r_mode, r_err, r_ovr, r_done, r_busy});
endmodule
